// File: rtl/writeback_pkg.sv
// Shared types and cache tag fields for the writeback stage.
package writeback_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2,
        StResp = 2'd3
    } wb_state_t;

    localparam logic       TAG_READ   = 1'b0;
    localparam logic       TAG_WRITE  = 1'b1;
    localparam logic [3:0] TAG_MEMORY = 4'b0001;
    localparam logic       TAG_DATA   = 1'b1;
    localparam logic [6:0] TAG_PAD    = 7'b0;

    localparam logic [12:0] STORE_TAG = {TAG_WRITE, TAG_MEMORY, TAG_DATA, TAG_PAD};

    // Stores are issued as aligned 8-byte beats.
    function automatic logic [63:0] align_addr(input logic [63:0] addr);
        return {addr[63:3], 3'b000};
    endfunction

endpackage

// File: rtl/wb_store_ctrl.sv
// Store FSM: issues the address and data beats to the data cache, then waits for completion.
module wb_store_ctrl
    import writeback_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        store_accept,
    input  logic [63:0] store_addr,
    input  logic [63:0] store_data,
    input  logic [63:0] store_rip,
    input  logic        req_ack,
    input  logic        resp_cyc,
    output logic        req_cyc,
    output logic [63:0] req_data,
    output logic [12:0] req_tag,
    output logic        resp_ack,
    output logic        retire,
    output logic [63:0] retire_rip,
    output logic        busy
);

    wb_state_t   state_q, state_d;
    logic [63:0] addr_q, data_q, rip_q;
    logic        resp_ack_q, retire_q;
    logic        resp_done;

    assign resp_done = (state_q == StResp) && resp_cyc;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (store_accept) state_d = StAddr;
            StAddr:  if (req_ack)      state_d = StData;
            StData:  if (req_ack)      state_d = StResp;
            StResp:  if (resp_cyc)     state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            data_q     <= '0;
            rip_q      <= '0;
            resp_ack_q <= 1'b0;
            retire_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            resp_ack_q <= resp_done;
            retire_q   <= resp_done;
            if (state_q == StIdle && store_accept) begin
                addr_q <= store_addr;
                data_q <= store_data;
                rip_q  <= store_rip;
            end
        end
    end

    // Request outputs decode straight from state so reset drops them at once.
    always_comb begin
        req_cyc  = 1'b0;
        req_data = '0;
        req_tag  = '0;
        case (state_q)
            StAddr: begin
                req_cyc  = 1'b1;
                req_data = addr_q;
                req_tag  = STORE_TAG;
            end
            StData: begin
                req_cyc  = 1'b1;
                req_data = data_q;
                req_tag  = STORE_TAG;
            end
            default: ;
        endcase
    end

    assign resp_ack   = resp_ack_q;
    assign retire     = retire_q;
    assign retire_rip = rip_q;
    assign busy       = (state_q != StIdle);

    resp_outside_wait: assert property (@(posedge clk) disable iff (!reset)
        resp_cyc |-> (state_q == StResp))
        else $error("cacheRespcyc seen outside the response wait");

endmodule

// File: rtl/writeback.sv
// Writeback stage: single-cycle register commits, multi-cycle stores via wb_store_ctrl.
module writeback
    import writeback_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        validIn,
    input  logic        canWritebackIn,
    input  logic [63:0] currentRipIn,
    input  logic [63:0] resultIn,
    input  logic [3:0]  destRegIn,
    input  logic        destRegValidIn,
    input  logic        isMemoryAccessDestIn,
    input  logic [63:0] memoryAddressDestIn,
    output logic        cacheReqcyc,
    output logic [63:0] cacheReq,
    output logic [12:0] cacheReqtag,
    input  logic        cacheReqack,
    input  logic        cacheRespcyc,
    output logic        cacheRespack,
    output logic        regWriteEnOut,
    output logic [3:0]  regWriteAddrOut,
    output logic [63:0] regWriteDataOut,
    output logic        retireValidOut,
    output logic [63:0] retireRipOut,
    output logic        stallOut,
    output logic        misalignOut
);

    logic        busy, accept, store_accept, alu_accept, store_retire;
    logic [63:0] store_rip;
    logic        wr_en_q, alu_retire_q;
    logic [3:0]  wr_addr_q;
    logic [63:0] wr_data_q, alu_rip_q;

    // Only the in-flight store gates acceptance; the store-accept stall must not block itself.
    assign accept       = validIn & canWritebackIn & ~busy;
    assign store_accept = accept & isMemoryAccessDestIn;
    assign alu_accept   = accept & ~isMemoryAccessDestIn;

    assign stallOut    = busy | store_accept;
    assign misalignOut = store_accept & (|memoryAddressDestIn[2:0]);

    wb_store_ctrl u_store_ctrl (
        .clk          (clk),
        .reset        (reset),
        .store_accept (store_accept),
        .store_addr   (align_addr(memoryAddressDestIn)),
        .store_data   (resultIn),
        .store_rip    (currentRipIn),
        .req_ack      (cacheReqack),
        .resp_cyc     (cacheRespcyc),
        .req_cyc      (cacheReqcyc),
        .req_data     (cacheReq),
        .req_tag      (cacheReqtag),
        .resp_ack     (cacheRespack),
        .retire       (store_retire),
        .retire_rip   (store_rip),
        .busy         (busy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            alu_retire_q <= 1'b0;
            alu_rip_q    <= '0;
        end else begin
            wr_en_q      <= alu_accept & destRegValidIn;
            alu_retire_q <= alu_accept;
            if (alu_accept & destRegValidIn) begin
                wr_addr_q <= destRegIn;
                wr_data_q <= resultIn;
            end
            if (alu_accept) begin
                alu_rip_q <= currentRipIn;
            end
        end
    end

    assign regWriteEnOut   = wr_en_q;
    assign regWriteAddrOut = wr_addr_q;
    assign regWriteDataOut = wr_data_q;

    // Store and ALU retires can never coincide: a store retire follows a non-IDLE cycle.
    assign retireValidOut = alu_retire_q | store_retire;
    assign retireRipOut   = store_retire ? store_rip : alu_rip_q;

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 Ports SHALL be as listed; clock and reset SHALL be named clk and reset, with one clock; reset SHALL be asynchronous and active-low.
REQ-002 clk  in  1  pipeline clock; all state SHALL update on posedge.
REQ-003 reset  in  1  asynchronous, active-low; low forces every register to its reset value immediately.
REQ-004 validIn  in  1  upstream (Memory stage) instruction valid.
REQ-005 canWritebackIn  in  1  pipeline permits this stage to act this cycle.
REQ-006 currentRipIn  in  64  RIP of the instruction.
REQ-007 resultIn  in  64  execute result to commit.
REQ-008 destRegIn  in  4  architectural destination register code.
REQ-009 destRegValidIn  in  1  destRegIn is meaningful.
REQ-010 isMemoryAccessDestIn  in  1  result goes to memory, not the register file.
REQ-011 memoryAddressDestIn  in  64  store byte address.
REQ-012 cacheReqcyc / cacheReq / cacheReqtag  out  1 / 64 / 13  store request to the data cache.
REQ-013 cacheReqack  in  1  cache accepted the current request beat.
REQ-014 cacheRespcyc / cacheRespack  in / out  1 / 1  store-completion response and its acknowledge.
REQ-015 regWriteEnOut / regWriteAddrOut / regWriteDataOut  out  1 / 4 / 64  register-file write port.
REQ-016 retireValidOut / retireRipOut  out  1 / 64  one-cycle retire pulse and retired RIP.
REQ-017 stallOut  out  1  upstream SHALL hold all inputs stable while high.
REQ-018 misalignOut  out  1  one-cycle pulse when a store address has a nonzero address[61:63].

Function
REQ-019 The FSM SHALL have four states: IDLE, ADDR, DATA and RESP.
REQ-020 An instruction SHALL be accepted in IDLE when validIn, canWritebackIn and !stallOut are all high.
REQ-021 A non-store accept (isMemoryAccessDestIn=0) SHALL pulse regWriteEnOut the next cycle, only if destRegValidIn=1, carrying destRegIn/resultIn, and SHALL pulse retireValidOut the same cycle; the FSM stays in IDLE, giving 1 instruction per cycle throughput.
REQ-022 A store accept SHALL go IDLE->ADDR and latch the address, data and RIP; regWriteEnOut SHALL stay 0 for that instruction.
REQ-023 In ADDR the stage SHALL drive cacheReqcyc=1, cacheReq={addr[0:60],3'b000} and cacheReqtag={WRITE,MEMORY,DATA,7'b0}; on cacheReqack it SHALL move to DATA.
REQ-024 In DATA the stage SHALL drive cacheReqcyc=1 and cacheReq=latched data; on cacheReqack it SHALL move to RESP with cacheReqcyc=0.
REQ-025 In RESP the stage SHALL wait for cacheRespcyc; in that cycle it SHALL assert cacheRespack for exactly 1 cycle (registered), return to IDLE, and pulse retireValidOut the following cycle.
REQ-026 stallOut SHALL be combinational: 1 in the store-accept cycle and whenever state!=IDLE; 0 in IDLE otherwise.
REQ-027 cacheReqack asserted outside ADDR/DATA SHALL be ignored.
REQ-028 cacheRespcyc outside RESP SHALL be ignored and SHALL flag a simulation assertion error.
REQ-029 misalignOut SHALL pulse in the store-accept cycle; the store still proceeds with the aligned address.
REQ-030 No new instruction SHALL be accepted while state!=IDLE; canWritebackIn=0 SHALL freeze IDLE acceptance but SHALL NOT stall an in-flight store.

Reset
REQ-031 Reset SHALL force: state=IDLE; cacheReqcyc, cacheRespack, regWriteEnOut, retireValidOut, misalignOut=0; cacheReq, cacheReqtag, regWriteAddrOut, regWriteDataOut, retireRipOut=0; stallOut=0.
REQ-032 Reset asserted mid-store SHALL abandon the store with no retire and no regWrite, and drop cacheReqcyc in the same cycle.

Structure
REQ-033 A shared package SHALL hold the wb_state_t enum and the tag field constants (READ/WRITE 1b, MEMORY 4b, DATA 1b, 7b pad = 13b).
REQ-034 The FSM plus the cache handshake SHALL be one sub-module, wb_store_ctrl; the top level holds the register-commit path and the output muxing.

Verification
REQ-035 Scenario 1: ALU op, destReg=3, result=0xDEAD_BEEF -> next cycle regWriteEn=1, addr=3, data=0xDEADBEEF, retire pulse with the RIP.
REQ-036 Scenario 2: store to 0x1000 with data 0x55; reqack at +2 and +4, respcyc at +7 -> ADDR/DATA beats correct, respack at +8, retire at +8, stall 0..+7, no regWrite.
REQ-037 Scenario 3: reqack tied high, respcyc 1 cycle after DATA -> minimum store of 4 cycles IDLE->IDLE.
REQ-038 Scenario 4: store to 0x1003 -> misalignOut pulse, cacheReq=0x1000.
REQ-039 Scenario 5: reset low while in RESP -> outputs reset immediately; a later respcyc is ignored and produces no retire.
REQ-040 Scenario 6: back-to-back ALU ops for 5 cycles with canWritebackIn toggling -> a commit occurs only in accepted cycles.
